// File: rtl/lsu_ecc_scrub_ctl_if.sv
// Bundle of the ECC scrub controller's dc3/dc4 error inputs, the store-buffer
// drain handshake and the shared DCCM write port. The slave side is the
// controller; the master side is whatever drives it (LSU datapath or a bench).
interface lsu_ecc_scrub_ctl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              dec_tlu_core_ecc_disable;
  logic              sec_lo_dc3;
  logic              sec_hi_dc3;
  logic              ded_dc3;
  logic [ADDR_W-1:0] addr_lo_dc3;
  logic [ADDR_W-1:0] addr_hi_dc3;
  logic [DATA_W-1:0] data_lo_dc3;
  logic [DATA_W-1:0] data_hi_dc3;
  logic              flush_dc4;
  logic              dccm_wr_stall;
  logic              stbuf_wr_req;
  logic [ADDR_W-1:0] stbuf_addr_any;
  logic [DATA_W-1:0] stbuf_data_any;
  logic              stbuf_wr_gnt;
  logic              dccm_wr_en;
  logic [ADDR_W-1:0] dccm_wr_addr;
  logic [DATA_W-1:0] dccm_wr_data;
  logic              dccm_wr_sel;
  logic              scrub_busy;
  logic              scrub_overflow;
  logic [15:0]       sec_count;
  logic              ded_pulse_dc4;

  modport slave (
    input  dec_tlu_core_ecc_disable, sec_lo_dc3, sec_hi_dc3, ded_dc3,
           addr_lo_dc3, addr_hi_dc3, data_lo_dc3, data_hi_dc3, flush_dc4,
           dccm_wr_stall, stbuf_wr_req, stbuf_addr_any, stbuf_data_any,
    output stbuf_wr_gnt, dccm_wr_en, dccm_wr_addr, dccm_wr_data, dccm_wr_sel,
           scrub_busy, scrub_overflow, sec_count, ded_pulse_dc4
  );

  modport master (
    output dec_tlu_core_ecc_disable, sec_lo_dc3, sec_hi_dc3, ded_dc3,
           addr_lo_dc3, addr_hi_dc3, data_lo_dc3, data_hi_dc3, flush_dc4,
           dccm_wr_stall, stbuf_wr_req, stbuf_addr_any, stbuf_data_any,
    input  stbuf_wr_gnt, dccm_wr_en, dccm_wr_addr, dccm_wr_data, dccm_wr_sel,
           scrub_busy, scrub_overflow, sec_count, ded_pulse_dc4
  );
endinterface

// File: rtl/lsu_ecc_scrub_ctl.sv
// ECC scrub controller: captures single-bit-corrected DCCM words in dc3,
// commits them in dc4 into a small merge-on-youngest queue, and shares the
// single DCCM write port with the store buffer under a starvation bound.
module lsu_ecc_scrub_ctl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input logic                 clk,
  input logic                 rst,
  lsu_ecc_scrub_ctl_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);
  localparam int WA_W  = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  // Saturating add used for the committed-word counter.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, a} + 17'(n);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // dc4 stage registers (valid/control reset, payload free-running)
  logic              vld_lo_p1, vld_hi_p1, ded_p1;
  logic [WA_W-1:0]   addr_lo_p1, addr_hi_p1;
  logic [DATA_W-1:0] data_lo_p1, data_hi_p1;

  // Scrub queue, word-addressed
  logic [WA_W-1:0]   q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  q_cnt;

  state_t            state, state_nxt;
  logic [ST_W-1:0]   starve, starve_nxt;
  logic              ovf_flag;
  logic [15:0]       sec_cnt;

  logic              cmt_lo, cmt_hi, scrub_wr, stbuf_gnt;
  logic              we_a, we_b, ovf_set, young_vld;
  logic [PTR_W-1:0]  idx_a, idx_b, young_idx, wr_ptr_nxt;
  logic [WA_W-1:0]   young_addr;
  logic [CNT_W-1:0]  cnt_nxt;

  // Byte-offset bits are irrelevant: everything here is word granular.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_lo_dc3[1:0], bus.addr_hi_dc3[1:0],
                              bus.stbuf_addr_any[1:0]};

  assign cmt_lo = vld_lo_p1 & ~bus.flush_dc4 & ~ded_p1;
  assign cmt_hi = vld_hi_p1 & ~bus.flush_dc4 & ~ded_p1;

  // A non-IDLE state always means the queue holds a head entry; the count
  // check just keeps an empty queue from ever producing a write.
  assign scrub_wr  = ~bus.dccm_wr_stall & (q_cnt != '0) &
                     ((state == FORCE) | ((state == PEND) & ~bus.stbuf_wr_req));
  assign stbuf_gnt = ~bus.dccm_wr_stall & bus.stbuf_wr_req & ~scrub_wr;

  // Enqueue planning: lo then hi, each merging into the youngest entry when
  // word addresses match, else taking a free slot (the slot freed by this
  // cycle's dequeue counts), else dropped with overflow flagged. An entry
  // leaving this cycle is not a merge target, so a merged word is never lost.
  always_comb begin
    we_a       = 1'b0;
    we_b       = 1'b0;
    idx_a      = '0;
    idx_b      = '0;
    ovf_set    = 1'b0;
    wr_ptr_nxt = wr_ptr;
    cnt_nxt    = q_cnt - CNT_W'(scrub_wr);
    young_vld  = (cnt_nxt != '0);
    young_idx  = wr_ptr - PTR_W'(1);
    young_addr = q_addr[young_idx];
    if (cmt_lo) begin
      if (young_vld && (addr_lo_p1 == young_addr)) begin
        we_a  = 1'b1;
        idx_a = young_idx;
      end else if (cnt_nxt < CNT_W'(DEPTH)) begin
        we_a       = 1'b1;
        idx_a      = wr_ptr_nxt;
        wr_ptr_nxt = wr_ptr_nxt + PTR_W'(1);
        cnt_nxt    = cnt_nxt + CNT_W'(1);
      end else begin
        ovf_set = 1'b1;
      end
      if (we_a) begin
        young_vld  = 1'b1;
        young_addr = addr_lo_p1;
        young_idx  = idx_a;
      end
    end
    if (cmt_hi) begin
      if (young_vld && (addr_hi_p1 == young_addr)) begin
        we_b  = 1'b1;
        idx_b = young_idx;
      end else if (cnt_nxt < CNT_W'(DEPTH)) begin
        we_b       = 1'b1;
        idx_b      = wr_ptr_nxt;
        wr_ptr_nxt = wr_ptr_nxt + PTR_W'(1);
        cnt_nxt    = cnt_nxt + CNT_W'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  // Next-state and starvation counter for the write-port arbiter.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve;
    case (state)
      IDLE: begin
        if (cnt_nxt != '0) state_nxt = PEND;
      end
      PEND: begin
        if (scrub_wr) begin
          starve_nxt = '0;
          state_nxt  = (cnt_nxt == '0) ? IDLE : PEND;
        end else if (stbuf_gnt) begin
          starve_nxt = starve + ST_W'(1);
          if (starve == ST_W'(STARVE_MAX - 1)) state_nxt = FORCE;
        end
      end
      FORCE: begin
        if (scrub_wr) begin
          starve_nxt = '0;
          state_nxt  = (cnt_nxt == '0) ? IDLE : PEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write-port mux: winner drives address/data/select, all zero when idle.
  always_comb begin
    bus.dccm_wr_en   = scrub_wr | stbuf_gnt;
    bus.dccm_wr_addr = '0;
    bus.dccm_wr_data = '0;
    bus.dccm_wr_sel  = 1'b0;
    if (scrub_wr) begin
      bus.dccm_wr_addr = {q_addr[rd_ptr], 2'b00};
      bus.dccm_wr_data = q_data[rd_ptr];
      bus.dccm_wr_sel  = 1'b1;
    end else if (stbuf_gnt) begin
      bus.dccm_wr_addr = {bus.stbuf_addr_any[ADDR_W-1:2], 2'b00};
      bus.dccm_wr_data = bus.stbuf_data_any;
    end
  end

  assign bus.stbuf_wr_gnt   = stbuf_gnt;
  assign bus.scrub_busy     = vld_lo_p1 | vld_hi_p1 | (q_cnt != '0);
  assign bus.scrub_overflow = ovf_flag;
  assign bus.sec_count      = sec_cnt;
  assign bus.ded_pulse_dc4  = ded_p1 & ~bus.flush_dc4;

  // Control state: dc3->dc4 valids, queue pointers, FSM, sticky/status regs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_lo_p1 <= 1'b0;
      vld_hi_p1 <= 1'b0;
      ded_p1    <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      q_cnt     <= '0;
      state     <= IDLE;
      starve    <= '0;
      ovf_flag  <= 1'b0;
      sec_cnt   <= '0;
    end else begin
      vld_lo_p1 <= bus.sec_lo_dc3 & ~bus.dec_tlu_core_ecc_disable;
      vld_hi_p1 <= bus.sec_hi_dc3 & ~bus.dec_tlu_core_ecc_disable;
      ded_p1    <= bus.ded_dc3 & ~bus.dec_tlu_core_ecc_disable;
      rd_ptr    <= rd_ptr + PTR_W'(scrub_wr);
      wr_ptr    <= wr_ptr_nxt;
      q_cnt     <= cnt_nxt;
      state     <= state_nxt;
      starve    <= starve_nxt;
      if (ovf_set) ovf_flag <= 1'b1;
      sec_cnt   <= sat_add(sec_cnt, {1'b0, cmt_lo} + {1'b0, cmt_hi});
    end
  end

  // Payload: dc4 address/data capture and queue storage writes.
  always_ff @(posedge clk) begin
    addr_lo_p1 <= bus.addr_lo_dc3[ADDR_W-1:2];
    addr_hi_p1 <= bus.addr_hi_dc3[ADDR_W-1:2];
    data_lo_p1 <= bus.data_lo_dc3;
    data_hi_p1 <= bus.data_hi_dc3;
    if (we_a) begin
      q_addr[idx_a] <= addr_lo_p1;
      q_data[idx_a] <= data_lo_p1;
    end
    if (we_b) begin
      q_addr[idx_b] <= addr_hi_p1;
      q_data[idx_b] <= data_hi_p1;
    end
  end

endmodule

// File: tb/tb_lsu_ecc_scrub_ctl.sv
// Directed bench for lsu_ecc_scrub_ctl: scrub latency, flush, DED handling,
// ECC disable, starvation-bounded arbitration, overflow/merge, reset.
module tb_lsu_ecc_scrub_ctl;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  lsu_ecc_scrub_ctl_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  lsu_ecc_scrub_ctl #(.ADDR_W(16), .DATA_W(32), .DEPTH(4), .STARVE_MAX(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_dc3();
    bus.sec_lo_dc3  = 1'b0;
    bus.sec_hi_dc3  = 1'b0;
    bus.ded_dc3     = 1'b0;
    bus.addr_lo_dc3 = '0;
    bus.addr_hi_dc3 = '0;
    bus.data_lo_dc3 = '0;
    bus.data_hi_dc3 = '0;
  endtask

  task automatic err_in(input logic lo, input logic hi, input logic [15:0] alo,
                        input logic [31:0] dlo, input logic [15:0] ahi,
                        input logic [31:0] dhi);
    bus.sec_lo_dc3  = lo;
    bus.sec_hi_dc3  = hi;
    bus.addr_lo_dc3 = alo;
    bus.data_lo_dc3 = dlo;
    bus.addr_hi_dc3 = ahi;
    bus.data_hi_dc3 = dhi;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic sel,
                        input logic [15:0] addr, input logic [31:0] data);
    chk({tag, "_en"},   32'(bus.dccm_wr_en),   32'(en));
    chk({tag, "_sel"},  32'(bus.dccm_wr_sel),  32'(sel));
    chk({tag, "_addr"}, 32'(bus.dccm_wr_addr), 32'(addr));
    chk({tag, "_data"}, bus.dccm_wr_data,      data);
  endtask

  logic [15:0] drain_addr [4];
  logic [31:0] drain_data [4];

  initial begin
    rst = 1'b1;
    clr_dc3();
    bus.dec_tlu_core_ecc_disable = 1'b0;
    bus.flush_dc4      = 1'b0;
    bus.dccm_wr_stall  = 1'b0;
    bus.stbuf_wr_req   = 1'b0;
    bus.stbuf_addr_any = '0;
    bus.stbuf_data_any = '0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_wr_en",    32'(bus.dccm_wr_en),     0);
    chk("rst_gnt",      32'(bus.stbuf_wr_gnt),   0);
    chk("rst_busy",     32'(bus.scrub_busy),     0);
    chk("rst_ovf",      32'(bus.scrub_overflow), 0);
    chk("rst_sec_cnt",  32'(bus.sec_count),      0);
    chk("rst_ded",      32'(bus.ded_pulse_dc4),  0);

    // Single lo error: write appears two cycles later
    err_in(1'b1, 1'b0, 16'h0104, 32'hDEADBEEF, 16'h0, 32'h0);
    settle();
    chk("t1_n_en", 32'(bus.dccm_wr_en), 0);
    tick();
    clr_dc3();
    settle();
    chk("t1_n1_busy", 32'(bus.scrub_busy), 1);
    chk("t1_n1_en",   32'(bus.dccm_wr_en), 0);
    tick();
    settle();
    chk_wr("t1_n2", 1'b1, 1'b1, 16'h0104, 32'hDEADBEEF);
    chk("t1_sec_cnt", 32'(bus.sec_count), 1);
    tick();
    settle();
    chk("t1_n3_en",   32'(bus.dccm_wr_en), 0);
    chk("t1_n3_busy", 32'(bus.scrub_busy), 0);

    // Lo+hi flushed in dc4: nothing written or counted
    err_in(1'b1, 1'b1, 16'h0104, 32'h11111111, 16'h0108, 32'h22222222);
    tick();
    clr_dc3();
    bus.flush_dc4 = 1'b1;
    settle();
    chk("t2f_ded", 32'(bus.ded_pulse_dc4), 0);
    tick();
    bus.flush_dc4 = 1'b0;
    settle();
    chk("t2f_en",      32'(bus.dccm_wr_en), 0);
    chk("t2f_busy",    32'(bus.scrub_busy), 0);
    chk("t2f_sec_cnt", 32'(bus.sec_count),  1);
    tick();

    // Lo+hi committed: two writes back to back, lo first
    err_in(1'b1, 1'b1, 16'h0104, 32'h11111111, 16'h0108, 32'h22222222);
    tick();
    clr_dc3();
    tick();
    settle();
    chk_wr("t2_lo", 1'b1, 1'b1, 16'h0104, 32'h11111111);
    tick();
    settle();
    chk_wr("t2_hi", 1'b1, 1'b1, 16'h0108, 32'h22222222);
    tick();
    settle();
    chk("t2_end_en",   32'(bus.dccm_wr_en), 0);
    chk("t2_sec_cnt",  32'(bus.sec_count),  3);

    // Double error alongside a single error: pulse only, no enqueue
    err_in(1'b1, 1'b0, 16'h0500, 32'h55555555, 16'h0, 32'h0);
    bus.ded_dc3 = 1'b1;
    tick();
    clr_dc3();
    settle();
    chk("t3_ded_hi", 32'(bus.ded_pulse_dc4), 1);
    tick();
    settle();
    chk("t3_ded_lo",  32'(bus.ded_pulse_dc4), 0);
    chk("t3_en",      32'(bus.dccm_wr_en),    0);
    chk("t3_busy",    32'(bus.scrub_busy),    0);
    chk("t3_sec_cnt", 32'(bus.sec_count),     3);

    // ECC disabled: neither the DED pulse nor the capture happens
    bus.dec_tlu_core_ecc_disable = 1'b1;
    err_in(1'b1, 1'b0, 16'h0500, 32'h55555555, 16'h0, 32'h0);
    bus.ded_dc3 = 1'b1;
    tick();
    clr_dc3();
    settle();
    chk("t3d_ded",  32'(bus.ded_pulse_dc4), 0);
    chk("t3d_busy", 32'(bus.scrub_busy),    0);
    tick();
    bus.dec_tlu_core_ecc_disable = 1'b0;
    settle();
    chk("t3d_en",      32'(bus.dccm_wr_en), 0);
    chk("t3d_sec_cnt", 32'(bus.sec_count),  3);

    // Starvation: 8 stbuf grants while pending, then a forced scrub
    bus.stbuf_wr_req   = 1'b1;
    bus.stbuf_addr_any = 16'h0203;
    bus.stbuf_data_any = 32'hAAAA5555;
    err_in(1'b1, 1'b0, 16'h0300, 32'h33333333, 16'h0, 32'h0);
    settle();
    chk("t4_n_gnt", 32'(bus.stbuf_wr_gnt), 1);
    tick();
    clr_dc3();
    settle();
    chk("t4_n1_gnt", 32'(bus.stbuf_wr_gnt), 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      settle();
      chk($sformatf("t4_lose%0d_gnt", i), 32'(bus.stbuf_wr_gnt), 1);
      chk_wr($sformatf("t4_lose%0d", i), 1'b1, 1'b0, 16'h0200, 32'hAAAA5555);
      tick();
    end
    settle();
    chk("t4_force_gnt", 32'(bus.stbuf_wr_gnt), 0);
    chk_wr("t4_force", 1'b1, 1'b1, 16'h0300, 32'h33333333);
    tick();
    settle();
    chk("t4_resume_gnt", 32'(bus.stbuf_wr_gnt), 1);
    chk_wr("t4_resume", 1'b1, 1'b0, 16'h0200, 32'hAAAA5555);
    chk("t4_sec_cnt", 32'(bus.sec_count), 4);
    tick();

    // Fill the queue under stbuf pressure, merge, then overflow
    err_in(1'b1, 1'b1, 16'h0400, 32'h000000A0, 16'h0404, 32'h000000A1);
    tick();
    err_in(1'b1, 1'b1, 16'h0408, 32'h000000A2, 16'h040C, 32'h000000A3);
    tick();
    err_in(1'b1, 1'b0, 16'h040C, 32'h0000A3A3, 16'h0, 32'h0);
    tick();
    err_in(1'b1, 1'b0, 16'h0410, 32'h000000A4, 16'h0, 32'h0);
    settle();
    chk("t5_full_ovf", 32'(bus.scrub_overflow), 0);
    tick();
    clr_dc3();
    settle();
    chk("t5_merge_ovf", 32'(bus.scrub_overflow), 0);
    chk("t5_busy",      32'(bus.scrub_busy),     1);
    tick();
    settle();
    chk("t5_drop_ovf", 32'(bus.scrub_overflow), 1);
    bus.stbuf_wr_req = 1'b0;
    drain_addr[0] = 16'h0400; drain_data[0] = 32'h000000A0;
    drain_addr[1] = 16'h0404; drain_data[1] = 32'h000000A1;
    drain_addr[2] = 16'h0408; drain_data[2] = 32'h000000A2;
    drain_addr[3] = 16'h040C; drain_data[3] = 32'h0000A3A3;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_wr($sformatf("t5_drain%0d", i), 1'b1, 1'b1, drain_addr[i], drain_data[i]);
      tick();
    end
    settle();
    chk("t5_empty_en",   32'(bus.dccm_wr_en),     0);
    chk("t5_empty_busy", 32'(bus.scrub_busy),     0);
    chk("t5_sticky_ovf", 32'(bus.scrub_overflow), 1);

    // Reset with three entries queued behind a stalled write port
    bus.dccm_wr_stall = 1'b1;
    bus.stbuf_wr_req  = 1'b1;
    err_in(1'b1, 1'b1, 16'h0600, 32'h66666660, 16'h0604, 32'h66666664);
    tick();
    err_in(1'b1, 1'b0, 16'h0608, 32'h66666668, 16'h0, 32'h0);
    tick();
    clr_dc3();
    tick();
    settle();
    chk("t6_stall_gnt", 32'(bus.stbuf_wr_gnt), 0);
    chk("t6_stall_en",  32'(bus.dccm_wr_en),   0);
    chk("t6_busy",      32'(bus.scrub_busy),   1);
    rst = 1'b1;
    tick();
    settle();
    chk("t6_rst_gnt",     32'(bus.stbuf_wr_gnt),   0);
    chk_wr("t6_rst", 1'b0, 1'b0, 16'h0, 32'h0);
    chk("t6_rst_busy",    32'(bus.scrub_busy),     0);
    chk("t6_rst_ovf",     32'(bus.scrub_overflow), 0);
    chk("t6_rst_sec_cnt", 32'(bus.sec_count),      0);
    chk("t6_rst_ded",     32'(bus.ded_pulse_dc4),  0);
    rst = 1'b0;
    bus.dccm_wr_stall = 1'b0;
    bus.stbuf_wr_req  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("t6_post%0d_en", i), 32'(bus.dccm_wr_en), 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_ecc_scrub_ctl.md
Name: lsu_ecc_scrub_ctl

Overview:
- Sequences corrected-data writeback to the DCCM after single-bit ECC errors reported in dc3, and arbitrates the single DCCM write port between store-buffer drain and scrub writes.
- Captures corrected lo/hi bank words in dc3, commits them in dc4 unless flushed, and queues them.
- Drains the queue under starvation-bounded arbitration.
- Sits in the LSU between the ECC decode/merge datapath, the store buffer and the DCCM write port.

Parameters:
ADDR_W, 16, DCCM byte-address width
DATA_W, 32, DCCM bank data width
DEPTH, 4, scrub queue entries (power of 2, >=2)
STARVE_MAX, 8, consecutive cycles a pending scrub may lose to stbuf before it is forced to win

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
dec_tlu_core_ecc_disable  in  1  suppress new captures (queue still drains)
sec_lo_dc3  in  1  single error corrected, lo bank
sec_hi_dc3  in  1  single error corrected, hi bank
ded_dc3  in  1  double error detected (either bank)
addr_lo_dc3  in  ADDR_W  lo bank address
addr_hi_dc3  in  ADDR_W  hi bank address
data_lo_dc3  in  DATA_W  corrected/merged lo word
data_hi_dc3  in  DATA_W  corrected/merged hi word
flush_dc4  in  1  kill the dc4 capture
dccm_wr_stall  in  1  write port unavailable this cycle
stbuf_wr_req  in  1  store buffer drain request
stbuf_addr_any  in  ADDR_W  stbuf drain address
stbuf_data_any  in  DATA_W  stbuf drain data
stbuf_wr_gnt  out  1  stbuf drain accepted this cycle
dccm_wr_en  out  1  DCCM write strobe
dccm_wr_addr  out  ADDR_W  write address; bits [1:0] forced 0
dccm_wr_data  out  DATA_W  write data; ECC encoded downstream
dccm_wr_sel  out  1  0 = stbuf, 1 = scrub
scrub_busy  out  1  queue non-empty or dc4 capture pending
scrub_overflow  out  1  sticky: an error was dropped because the queue was full
sec_count  out  16  saturating count of committed single-error words
ded_pulse_dc4  out  1  one-cycle pulse, double error committed in dc4

Behaviour:
- Reset (rst=1 at clk edge), taking effect the same edge and applying mid-operation: queue emptied, dc4 regs invalid, starve counter 0, FSM=IDLE. All outputs 0 after the edge. No write from a pre-reset entry ever issues.
- dc3->dc4 capture (registered):
  - v_lo4 <= sec_lo_dc3 & ~disable.
  - v_hi4 <= sec_hi_dc3 & ~disable.
  - ded4 <= ded_dc3 & ~disable.
  - Addr and data are registered with them.
- dc4 commit:
  - If flush_dc4, drop all.
  - Else, if ded4, assert ded_pulse_dc4 and do not enqueue either word; a corrupt line is never scrubbed.
  - Else, enqueue lo then hi, in that order, on the same edge.
  - sec_count += number of committed words, saturating at 0xFFFF.
- Enqueue rules:
  - An entry whose word address equals the youngest valid entry's address overwrites that entry's data (merge). No new slot is used.
  - Otherwise it takes a free slot.
  - Lo and hi committed together with only one free slot: lo enqueued, hi dropped, scrub_overflow set.
  - Full queue: word dropped, scrub_overflow set. scrub_overflow clears only on rst.
  - Enqueue and dequeue on the same edge: the dequeued slot counts as free.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE, when the queue is empty. Moves to PEND when the queue is non-empty.
  - PEND: the scrub head competes with stbuf.
  - FORCE, entered when starve_cnt == STARVE_MAX-1 and scrub loses again: scrub wins the next unstalled cycle.
  - After a scrub write: go to IDLE if the queue becomes empty, else to PEND.
- Arbitration, each cycle with dccm_wr_stall=0:
  - In FORCE, or in PEND with stbuf_wr_req=0: the scrub head is written and dequeued, and starve_cnt is set to 0.
  - Otherwise, if stbuf_wr_req=1: stbuf_wr_gnt=1 and stbuf is written. starve_cnt increments only while in PEND.
  - dccm_wr_stall=1: no grant, no write, no dequeue, starve_cnt holds, state holds.
- Write output is combinational from the arbitration decision. dccm_wr_en = stbuf_wr_gnt | scrub write. Addr, data and sel come from the winner. Zero when idle.
- Scrub latency: error in dc3 at cycle N, no contention → dccm_wr_en with sel=1 at cycle N+2.
- dec_tlu_core_ecc_disable affects capture only.
- scrub_busy = v_lo4 | v_hi4 | queue non-empty.

Test Plan:
- sec_lo_dc3=1, addr 0x0104, data 0xDEADBEEF, no stbuf traffic → cycle N+2: dccm_wr_en=1, sel=1, addr 0x0104, data 0xDEADBEEF; sec_count=1.
- sec_lo and sec_hi both set (0x0104/0x0108) with flush_dc4=1 → no write, sec_count=0. Repeat without flush → two scrub writes, lo first, on consecutive cycles.
- Scrub pending with stbuf_wr_req held high, STARVE_MAX=8 → 8 stbuf grants, then one scrub write (stbuf_wr_gnt=0 that cycle), then stbuf grants resume.
- DEPTH=4 with stbuf always requesting → 5 distinct error words: the 5th is dropped and scrub_overflow=1. A repeat error on the youngest entry's address merges and adds no entry.
- ded_dc3=1 with sec_lo_dc3=1 → ded_pulse_dc4 high for exactly 1 cycle, no enqueue. With dec_tlu_core_ecc_disable=1 → no pulse, no count.
- rst asserted with 3 queued entries and dccm_wr_stall=1 → after the edge all outputs 0, and no scrub write occurs after stall release.
